spi_regbank: RTL and testbench

Parametrised SPI register-bank peripheral: the successor to the write-only 5×8-bit SPI control block. It adds configurable register count and width, selectable SPI mode (CPOL/CPHA) and read-back over CIPO. It also reports a write strobe and frame errors. It sits between the chip-level SPI pins and the output/PWM control logic, which consume the flat `regs_out` bus.

---
 rtl/spi_regbank.sv | 172 +++++++++++++++++
 tb/tb_spi_regbank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank.sv
// spi_regbank: SPI register-bank peripheral with configurable register count
// and width, selectable CPOL/CPHA, read-back over CIPO, a write strobe and a
// frame-error pulse.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   nCS, SCLK, COPI SPI pins, asynchronous to clk
//   CIPO, CIPO_oe   read-back data and its tristate enable
//   regs_out        flat register bus, register i at [i*DATA_W +: DATA_W]
//   wr_strobe       one-cycle pulse per committed write
//   wr_addr         address of the last committed write
//   frame_err       one-cycle pulse per rejected frame
module spi_regbank #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  logic                 ncs_p0, ncs_p1, ncs_p2;
  logic                 sclk_p0, sclk_p1, sclk_p2;
  logic                 copi_p0, copi_p1;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   shift_sr;
  logic [FRAME_W-1:0]   shift_nx;
  logic [DATA_W-1:0]    rd_shift;
  logic [DATA_W-1:0]    rd_val;
  logic                 rd_active;
  logic                 cipo_q;
  logic                 lead_edge, trail_edge, sample_edge, drive_edge;
  logic                 ncs_fall, ncs_rise, sample_ok, snap_now;
  logic [ADDR_W-1:0]    snap_addr;
  logic                 fr_rw, fr_full;
  logic [ADDR_W-1:0]    fr_addr;
  logic [DATA_W-1:0]    fr_data;

  // Bit counter stops one past a full frame so any overrun stays visible.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(FRAME_W + 1)) ? c : c + 1'b1;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS);
  endfunction

  // ---- stage p0/p1: synchronisers, p2: edge-detect history ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_p0  <= 1'b1;
      ncs_p1  <= 1'b1;
      ncs_p2  <= 1'b1;
      sclk_p0 <= CPOL;
      sclk_p1 <= CPOL;
      sclk_p2 <= CPOL;
    end else begin
      ncs_p0  <= nCS;
      ncs_p1  <= ncs_p0;
      ncs_p2  <= ncs_p1;
      sclk_p0 <= SCLK;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
    end
  end

  always_ff @(posedge clk) begin
    copi_p0 <= COPI;
    copi_p1 <= copi_p0;
  end

  // ---- edge decode on synchronised signals ----
  assign lead_edge   = (sclk_p2 == CPOL) && (sclk_p1 != CPOL);
  assign trail_edge  = (sclk_p2 != CPOL) && (sclk_p1 == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge  : trail_edge;
  assign ncs_fall    = ncs_p2 && !ncs_p1;
  assign ncs_rise    = !ncs_p2 && ncs_p1;
  // A sample edge coinciding with nCS rising is dropped: ncs_p1 is already high.
  assign sample_ok   = sample_edge && !ncs_p1 && !ncs_fall;

  assign shift_nx  = {shift_sr[FRAME_W-2:0], copi_p1};
  // The sample edge that completes R/W + address triggers the read snapshot.
  assign snap_now  = sample_ok && (bit_cnt == CNT_W'(ADDR_W));
  assign snap_addr = shift_nx[ADDR_W-1:0];

  // Unmatched addresses fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (snap_addr == ADDR_W'(i)) rd_val = regs_out[i*DATA_W +: DATA_W];
    end
  end

  assign fr_rw   = shift_sr[FRAME_W-1];
  assign fr_addr = shift_sr[DATA_W +: ADDR_W];
  assign fr_data = shift_sr[DATA_W-1:0];
  assign fr_full = (bit_cnt == CNT_W'(FRAME_W));

  // ---- frame capture and read shifter ----
  always_ff @(posedge clk) begin
    if (ncs_fall)       shift_sr <= '0;
    else if (sample_ok) shift_sr <= shift_nx;

    if (snap_now)                                rd_shift <= rd_val;
    else if (rd_active && drive_edge && !ncs_p1) rd_shift <= rd_shift << 1;
  end

  // ---- control, read-back output and commit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rd_active <= 1'b0;
      cipo_q    <= 1'b0;
      regs_out  <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;

      if (ncs_fall) begin
        bit_cnt   <= '0;
        rd_active <= 1'b0;
      end else if (sample_ok) begin
        bit_cnt <= cnt_sat_inc(bit_cnt);
        if (snap_now) rd_active <= ~shift_nx[ADDR_W];
      end

      if (ncs_p1) begin
        rd_active <= 1'b0;
        cipo_q    <= 1'b0;
      end else if (rd_active && drive_edge) begin
        cipo_q <= rd_shift[DATA_W-1];
      end

      if (ncs_rise) begin
        if (bit_cnt != '0 && !fr_full) begin
          frame_err <= 1'b1;
        end else if (fr_full && !addr_ok(fr_addr)) begin
          frame_err <= 1'b1;
        end else if (fr_full && fr_rw) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (fr_addr == ADDR_W'(i)) regs_out[i*DATA_W +: DATA_W] <= fr_data;
          end
          wr_strobe <= 1'b1;
          wr_addr   <= fr_addr;
        end
      end
    end
  end

  // Gating with ncs_p1 drops CIPO in the same cycle the frame closes.
  assign CIPO    = cipo_q && !ncs_p1;
  assign CIPO_oe = !ncs_p1;

endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: bench for spi_regbank. Four instances cover CPOL/CPHA 00,
// 01, 10, 11 with the default geometry; a fifth uses 16 x 16-bit registers
// with a 4-bit address. A transaction-level register model predicts
// regs_out, wr_strobe, wr_addr and frame_err every cycle.
module tb_spi_regbank;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   ncs, sclk, copi;
  logic [N-1:0]   cipo, oe, strobe, ferr;
  logic [255:0]   regs_w [N];
  logic [6:0]     waddr_w [N];
  logic [39:0]    r_small [4];
  logic [255:0]   r_big;
  logic [3:0]     wa_big;
  logic [255:0]   sh_c;

  int checks = 0;
  int errors = 0;
  int strb_cnt [N];
  int ferr_cnt [N];

  logic [15:0]    exp_reg [N][16];
  logic           exp_strobe [N];
  logic           exp_err [N];
  logic [6:0]     exp_waddr [N];
  logic           idle [N];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_mode
    spi_regbank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7),
                  .CPOL(i >= 2), .CPHA(i % 2 == 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .nCS(ncs[i]), .SCLK(sclk[i]), .COPI(copi[i]),
      .CIPO(cipo[i]), .CIPO_oe(oe[i]), .regs_out(r_small[i]),
      .wr_strobe(strobe[i]), .wr_addr(waddr_w[i]), .frame_err(ferr[i]));
    assign regs_w[i] = {216'd0, r_small[i]};
  end

  spi_regbank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4),
                .CPOL(1'b0), .CPHA(1'b0)) u_big (
    .clk(clk), .rst_n(rst_n), .nCS(ncs[4]), .SCLK(sclk[4]), .COPI(copi[4]),
    .CIPO(cipo[4]), .CIPO_oe(oe[4]), .regs_out(r_big),
    .wr_strobe(strobe[4]), .wr_addr(wa_big), .frame_err(ferr[4]));
  assign regs_w[4]  = r_big;
  assign waddr_w[4] = {3'd0, wa_big};

  function automatic int nr_f(input int m);  return (m == 4) ? 16 : 5; endfunction
  function automatic int dw_f(input int m);  return (m == 4) ? 16 : 8; endfunction
  function automatic int aw_f(input int m);  return (m == 4) ? 4 : 7;  endfunction
  function automatic logic cpol_f(input int m); return (m == 2 || m == 3); endfunction
  function automatic logic cpha_f(input int m); return (m == 1 || m == 3); endfunction

  function automatic logic [15:0] reg_of(input int m, input int r);
    logic [255:0] s;
    s = regs_w[m] >> (r * dw_f(m));
    return (dw_f(m) == 16) ? s[15:0] : {8'd0, s[7:0]};
  endfunction

  task automatic chk(input string nm, input int m, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h exp %h at %0t", nm, m, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int m = 0; m < N; m++) begin
      for (int r = 0; r < nr_f(m); r++) begin
        chk("regs_out", m, 32'(reg_of(m, r)), 32'(exp_reg[m][r]));
      end
      chk("wr_strobe", m, 32'(strobe[m]), 32'(exp_strobe[m]));
      chk("frame_err", m, 32'(ferr[m]), 32'(exp_err[m]));
      chk("wr_addr", m, 32'(waddr_w[m]), 32'(exp_waddr[m]));
      if (idle[m]) begin
        chk("cipo_idle", m, 32'(cipo[m]), 32'd0);
        chk("cipo_oe_idle", m, 32'(oe[m]), 32'd0);
      end
      strb_cnt[m] += int'(strobe[m]);
      ferr_cnt[m] += int'(ferr[m]);
    end
  end

  task automatic model_clear_all();
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 16; r++) exp_reg[k][r] = '0;
      exp_strobe[k] = 1'b0;
      exp_err[k]    = 1'b0;
      exp_waddr[k]  = '0;
      idle[k]       = 1'b1;
    end
  endtask

  // Outcome of a frame of nbits bits (value right-aligned, sent MSB first).
  task automatic model_commit(input int m, input logic [31:0] val, input int nbits);
    int fw, addr;
    fw = 1 + aw_f(m) + dw_f(m);
    if (nbits == 0) return;
    if (nbits != fw) begin
      exp_err[m] = 1'b1;
      return;
    end
    addr = int'((val >> dw_f(m)) & ((32'd1 << aw_f(m)) - 1));
    if (addr >= nr_f(m)) begin
      exp_err[m] = 1'b1;
    end else if (val[fw-1]) begin
      exp_reg[m][addr] = 16'(val & ((32'd1 << dw_f(m)) - 1));
      exp_strobe[m]    = 1'b1;
      exp_waddr[m]     = 7'(addr);
    end
  endtask

  // Drives one frame on instance m. abort > 0 asserts rst_n after that many bits.
  task automatic frame(input int m, input logic [31:0] val, input int nbits,
                       input int abort, output logic [15:0] rd);
    int fw, idx, addr;
    logic [15:0] rd_exp;
    fw   = 1 + aw_f(m) + dw_f(m);
    addr = int'((val >> dw_f(m)) & ((32'd1 << aw_f(m)) - 1));
    rd_exp = (addr < nr_f(m)) ? exp_reg[m][addr] : 16'd0;
    rd = '0;
    idle[m] = 1'b0;
    ncs[m]  = 1'b0;
    tick(4);
    for (int b = nbits - 1; b >= 0; b--) begin
      idx = nbits - 1 - b;
      if (abort > 0 && idx == abort) break;
      if (!cpha_f(m)) begin
        copi[m] = val[b];
        tick(4);
      end else begin
        sclk[m] = ~cpol_f(m);
        copi[m] = val[b];
        tick(4);
      end
      chk("cipo_oe_active", m, 32'(oe[m]), 32'd1);
      if (nbits == fw && idx > aw_f(m)) rd = {rd[14:0], cipo[m]};
      if (!cpha_f(m)) begin
        sclk[m] = ~cpol_f(m);
        tick(4);
        sclk[m] = cpol_f(m);
      end else begin
        sclk[m] = cpol_f(m);
        tick(4);
      end
    end
    if (abort > 0) begin
      rst_n = 1'b0;
      model_clear_all();
      ncs[m]  = 1'b1;
      sclk[m] = cpol_f(m);
      copi[m] = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      return;
    end
    tick(4);
    ncs[m] = 1'b1;
    tick(1);
    chk("cipo_oe_hold", m, 32'(oe[m]), 32'd1);
    tick(1);
    chk("cipo_oe_drop", m, 32'(oe[m]), 32'd0);
    chk("cipo_close", m, 32'(cipo[m]), 32'd0);
    tick(1);
    model_commit(m, val, nbits);
    tick(1);
    exp_strobe[m] = 1'b0;
    exp_err[m]    = 1'b0;
    idle[m]       = 1'b1;
    if (nbits == fw && !val[fw-1]) chk("rd_model", m, 32'(rd), 32'(rd_exp));
    tick(4);
  endtask

  task automatic run_mode(input int m);
    int fw, dw;
    logic [31:0] wbit;
    logic [15:0] rd;
    fw   = 1 + aw_f(m) + dw_f(m);
    dw   = dw_f(m);
    wbit = 32'd1 << (fw - 1);
    frame(m, wbit | (32'd1 << dw) | 32'h55, fw, 0, rd);
    chk("lit_reg1", m, 32'(reg_of(m, 1)), 32'h55);
    chk("lit_waddr1", m, 32'(waddr_w[m]), 32'd1);
    frame(m, wbit | (32'd4 << dw) | 32'hA7, fw, 0, rd);
    frame(m, 32'd4 << dw, fw, 0, rd);
    chk("lit_rd4", m, 32'(rd), 32'hA7);
    chk("lit_waddr4", m, 32'(waddr_w[m]), 32'd4);
    if (nr_f(m) <= 10) begin
      frame(m, wbit | (32'd10 << dw) | 32'h12, fw, 0, rd);
      frame(m, 32'd10 << dw, fw, 0, rd);
      chk("lit_rd10", m, 32'(rd), 32'h0);
    end else begin
      frame(m, wbit | (32'd3 << dw) | 32'hBEEF, fw, 0, rd);
      frame(m, 32'd3 << dw, fw, 0, rd);
      chk("lit_rd3", m, 32'(rd), 32'hBEEF);
    end
    frame(m, 32'h80F, 12, 0, rd);
    frame(m, 32'h203FF, 18, 0, rd);
    frame(m, 32'h0, 0, 0, rd);
    chk("lit_reg4", m, 32'(reg_of(m, 4)), 32'hA7);
    chk("lit_strobes", m, 32'(strb_cnt[m]), (m == 4) ? 32'd3 : 32'd2);
    chk("lit_errors", m, 32'(ferr_cnt[m]), (m == 4) ? 32'd2 : 32'd4);
  endtask

  initial begin
    logic [15:0] rd;
    ncs  = '1;
    copi = '0;
    for (int m = 0; m < N; m++) begin
      sclk[m]     = cpol_f(m);
      strb_cnt[m] = 0;
      ferr_cnt[m] = 0;
    end
    model_clear_all();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("lit_reset_regs", 0, 32'(regs_w[0]), 32'd0);
    chk("lit_reset_oe", 0, 32'(oe), 32'd0);

    for (int m = 0; m < N; m++) run_mode(m);

    frame(0, 32'h8233, 16, 9, rd);
    chk("lit_rst_regs", 0, regs_w[0][31:0], 32'd0);
    chk("lit_rst_waddr", 0, 32'(waddr_w[0]), 32'd0);
    frame(0, 32'h8233, 16, 0, rd);
    chk("lit_after_rst_reg2", 0, 32'(reg_of(0, 2)), 32'h33);
    chk("lit_after_rst_waddr", 0, 32'(waddr_w[0]), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
